// File: rtl/asteroids_pkg.sv
// asteroids_pkg: shared screen geometry, coordinate widths and hit tracker states.
package asteroids_pkg;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam logic [X_W-1:0] SCREEN_W = 8'd160;
    localparam logic [Y_W-1:0] SCREEN_H = 7'd120;
    typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} hit_state_t;
endpackage

// File: rtl/frame_hit_accumulator.sv
// frame_hit_accumulator: folds raster overlap hits into one per-frame hit flag and first-hit coordinate.
module frame_hit_accumulator
    import asteroids_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           restart,
    input  logic           frame_start,
    input  logic           frame_done,
    input  logic           hit_valid,
    input  logic [X_W-1:0] hit_x,
    input  logic [Y_W-1:0] hit_y,
    output logic           frame_eval,
    output logic           eval_hit,
    output logic [X_W-1:0] eval_x,
    output logic [Y_W-1:0] eval_y
);
    logic           frame_open;
    logic           frame_hit;
    logic [X_W-1:0] pending_x;
    logic [Y_W-1:0] pending_y;
    logic           hit_now;
    logic           new_hit;

    assign hit_now    = hit_valid && hit_x < SCREEN_W && hit_y < SCREEN_H;
    assign frame_eval = frame_done && frame_open;
    // A hit coincident with frame_done still belongs to the closing frame.
    assign eval_hit   = frame_hit || hit_now;
    assign eval_x     = frame_hit ? pending_x : hit_x;
    assign eval_y     = frame_hit ? pending_y : hit_y;
    assign new_hit    = frame_start ? hit_now && !frame_done : frame_open && hit_now && !frame_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_open <= 1'b0;
            frame_hit  <= 1'b0;
            pending_x  <= '0;
            pending_y  <= '0;
        end else if (restart) begin
            frame_open <= 1'b0;
            frame_hit  <= 1'b0;
            pending_x  <= '0;
            pending_y  <= '0;
        end else begin
            frame_open <= frame_start || (frame_open && !frame_done);
            frame_hit  <= frame_start || frame_done ? new_hit : frame_hit || new_hit;
            if (new_hit) begin
                pending_x <= hit_x;
                pending_y <= hit_y;
            end
        end
    end
endmodule

// File: rtl/hit_event_tracker.sv
// hit_event_tracker: per-frame collision decision with lives/invulnerability/game-over FSM.
// Optional frame-survived score counter enabled by HIT_EVENT_SCORE_EN.
module hit_event_tracker
    import asteroids_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_start,
    input  logic           frame_done,
    input  logic           hit_valid,
    input  logic [X_W-1:0] hit_x,
    input  logic [Y_W-1:0] hit_y,
    input  logic           restart,
    output logic           collision,
    output logic [X_W-1:0] first_x,
    output logic [Y_W-1:0] first_y,
    output logic [2:0]     lives,
    output logic           invuln,
    output logic           game_over,
    output logic [15:0]    score
);
    logic           frame_eval;
    logic           eval_hit;
    logic [X_W-1:0] eval_x;
    logic [Y_W-1:0] eval_y;
    hit_state_t     state, state_n;
    logic [7:0]     inv_cnt, inv_cnt_n;
    logic [2:0]     lives_n;
    logic [X_W-1:0] first_x_n;
    logic [Y_W-1:0] first_y_n;
    logic           collision_n;

    frame_hit_accumulator u_acc (
        .clock       (clock),
        .reset       (reset),
        .restart     (restart),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .hit_valid   (hit_valid),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .frame_eval  (frame_eval),
        .eval_hit    (eval_hit),
        .eval_x      (eval_x),
        .eval_y      (eval_y)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= PLAY;
            inv_cnt   <= '0;
            lives     <= 3'(LIVES_INIT);
            first_x   <= '0;
            first_y   <= '0;
            collision <= 1'b0;
        end else begin
            state     <= state_n;
            inv_cnt   <= inv_cnt_n;
            lives     <= lives_n;
            first_x   <= first_x_n;
            first_y   <= first_y_n;
            collision <= collision_n;
        end
    end

    always_comb begin
        state_n     = state;
        inv_cnt_n   = inv_cnt;
        lives_n     = lives;
        first_x_n   = first_x;
        first_y_n   = first_y;
        collision_n = 1'b0;
        if (restart) begin
            state_n   = PLAY;
            inv_cnt_n = '0;
            lives_n   = 3'(LIVES_INIT);
            first_x_n = '0;
            first_y_n = '0;
        end else if (frame_eval && state == PLAY && eval_hit) begin
            collision_n = 1'b1;
            lives_n     = lives - 3'd1;
            first_x_n   = eval_x;
            first_y_n   = eval_y;
            state_n     = lives == 3'd1 ? GAME_OVER : INVULN;
            inv_cnt_n   = 8'(INVULN_FRAMES);
        end else if (frame_eval && state == INVULN) begin
            inv_cnt_n = inv_cnt == 8'd0 ? 8'd0 : inv_cnt - 8'd1;
            state_n   = inv_cnt <= 8'd1 ? PLAY : INVULN;
        end
    end

    assign invuln    = state == INVULN;
    assign game_over = state == GAME_OVER;

`ifdef HIT_EVENT_SCORE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            score <= '0;
        else if (restart)
            score <= '0;
        else if (frame_eval && state == PLAY && !eval_hit && score != 16'hFFFF)
            score <= score + 16'd1;
    end
`else
    assign score = '0;
`endif
endmodule

// File: tb/tb_hit_event_tracker.sv
// tb_hit_event_tracker: directed scoreboard bench for hit_event_tracker (LIVES_INIT=3, INVULN_FRAMES=2).
module tb_hit_event_tracker;
    typedef struct {
        logic        col;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  lives;
        logic        inv;
        logic        go;
        logic [15:0] score;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_done = 1'b0;
    logic        hit_valid = 1'b0;
    logic [7:0]  hit_x = '0;
    logic [6:0]  hit_y = '0;
    logic        restart = 1'b0;
    logic        collision;
    logic [7:0]  first_x;
    logic [6:0]  first_y;
    logic [2:0]  lives;
    logic        invuln;
    logic        game_over;
    logic [15:0] score;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    int          m_state;
    int          m_inv;
    logic [2:0]  m_lives;
    logic [7:0]  m_fx;
    logic [6:0]  m_fy;
    logic [15:0] m_score;

    hit_event_tracker #(.LIVES_INIT(3), .INVULN_FRAMES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .hit_valid   (hit_valid),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .restart     (restart),
        .collision   (collision),
        .first_x     (first_x),
        .first_y     (first_y),
        .lives       (lives),
        .invuln      (invuln),
        .game_over   (game_over),
        .score       (score)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_inv   = 0;
        m_lives = 3'd3;
        m_fx    = '0;
        m_fy    = '0;
        m_score = '0;
    endtask

    task automatic model_eval(input bit had_hit, input logic [7:0] fx, input logic [6:0] fy);
        exp_t e;
        e.col = 1'b0;
        if (m_state == 0 && had_hit) begin
            e.col   = 1'b1;
            m_lives = m_lives - 3'd1;
            m_fx    = fx;
            m_fy    = fy;
            m_state = m_lives == 3'd0 ? 2 : 1;
            m_inv   = 2;
        end else if (m_state == 0) begin
`ifdef HIT_EVENT_SCORE_EN
            if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
`endif
        end else if (m_state == 1) begin
            m_inv = m_inv - 1;
            if (m_inv == 0) m_state = 0;
        end
        e.x = m_fx;
        e.y = m_fy;
        e.lives = m_lives;
        e.inv = m_state == 1;
        e.go = m_state == 2;
        e.score = m_score;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("collision", 32'(collision), 32'(e.col));
        chk("first_x", 32'(first_x), 32'(e.x));
        chk("first_y", 32'(first_y), 32'(e.y));
        chk("lives", 32'(lives), 32'(e.lives));
        chk("invuln", 32'(invuln), 32'(e.inv));
        chk("game_over", 32'(game_over), 32'(e.go));
        chk("score", 32'(score), 32'(e.score));
        cyc();
        chk("pulse_end", 32'(collision), 32'd0);
    endtask

    task automatic start_f();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic hit(input logic [7:0] x, input logic [6:0] y);
        hit_valid = 1'b1;
        hit_x = x;
        hit_y = y;
        cyc();
        hit_valid = 1'b0;
    endtask

    task automatic done_f(input bit hv, input logic [7:0] x, input logic [6:0] y, input bit st,
                          input bit had_hit, input logic [7:0] fx, input logic [6:0] fy);
        model_eval(had_hit, fx, fy);
        frame_done = 1'b1;
        frame_start = st;
        hit_valid = hv;
        hit_x = x;
        hit_y = y;
        cyc();
        frame_done = 1'b0;
        frame_start = 1'b0;
        hit_valid = 1'b0;
        check();
    endtask

    task automatic plain_frame(input bit had_hit, input logic [7:0] x, input logic [6:0] y);
        start_f();
        if (had_hit) hit(x, y);
        done_f(0, 0, 0, 0, had_hit, x, y);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_collision", 32'(collision), 32'd0);
        chk("rst_first", {first_x, first_y}, 32'd0);
        chk("rst_flags", {invuln, game_over}, 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        reset = 1'b0;
        cyc();
        // first hit coordinate wins within a frame
        start_f();
        hit(8'd10, 7'd20);
        hit(8'd50, 7'd60);
        done_f(0, 0, 0, 0, 1, 8'd10, 7'd20);
        plain_frame(1, 8'd70, 7'd70);
        plain_frame(1, 8'd71, 7'd71);
        // out-of-range coordinates only
        start_f();
        hit(8'd160, 7'd5);
        hit(8'd3, 7'd120);
        done_f(0, 0, 0, 0, 0, 0, 0);
        // partial frame discarded by a second frame_start
        start_f();
        hit(8'd7, 7'd7);
        start_f();
        done_f(0, 0, 0, 0, 0, 0, 0);
        // hit in the frame_done cycle belongs to the closing frame
        start_f();
        done_f(1, 8'd33, 7'd44, 0, 1, 8'd33, 7'd44);
        plain_frame(0, 0, 0);
        plain_frame(0, 0, 0);
        // hit in the frame_start cycle belongs to the new frame; last life
        frame_start = 1'b1;
        hit_valid = 1'b1;
        hit_x = 8'd5;
        hit_y = 7'd6;
        cyc();
        frame_start = 1'b0;
        hit_valid = 1'b0;
        done_f(0, 0, 0, 0, 1, 8'd5, 7'd6);
        plain_frame(1, 8'd9, 7'd9);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        model_reset();
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_go", 32'(game_over), 32'd0);
        chk("restart_first", {first_x, first_y}, 32'd0);
        chk("restart_score", 32'(score), 32'd0);
        for (int i = 0; i < 5; i++) plain_frame(0, 0, 0);
        plain_frame(1, 8'd20, 7'd30);
        plain_frame(1, 8'd21, 7'd31);
        plain_frame(1, 8'd22, 7'd32);
        // restart coincident with frame_done suppresses the collision
        start_f();
        hit(8'd1, 7'd1);
        frame_done = 1'b1;
        restart = 1'b1;
        cyc();
        frame_done = 1'b0;
        restart = 1'b0;
        model_reset();
        chk("rs_done_collision", 32'(collision), 32'd0);
        chk("rs_done_lives", 32'(lives), 32'd3);
        chk("rs_done_score", 32'(score), 32'd0);
        // frame_start with frame_done: evaluate old frame, open a clean one
        start_f();
        hit(8'd1, 7'd2);
        done_f(0, 0, 0, 1, 1, 8'd1, 7'd2);
        done_f(0, 0, 0, 0, 0, 0, 0);
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        chk("stray_done_invuln", 32'(invuln), 32'd1);
        plain_frame(0, 0, 0);
        // asynchronous reset mid-frame
        start_f();
        hit(8'd3, 7'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_lives", 32'(lives), 32'd3);
        chk("arst_first", {first_x, first_y}, 32'd0);
        chk("arst_flags", {collision, invuln, game_over}, 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        reset = 1'b0;
        cyc();
        model_reset();
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        chk("arst_frame_closed", 32'(collision), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
